// File: rtl/toggle_activity_monitor_pkg.sv
// Shared types and default sizing for the toggle activity monitor.
// The state enum and the default widths live here so the interface, top and popcount agree.
package act_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACCUM,
        REPORT
    } state_e;

    localparam int DEF_VEC_W = 66;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_WIN_W = 16;

    // Bits needed to hold a per-interval toggle count in the range 0..vec_w.
    function automatic int cnt_width(input int vec_w);
        return $clog2(vec_w + 1);
    endfunction

endpackage

// File: rtl/toggle_activity_monitor_if.sv
// Control, sample and result bundle of the toggle activity monitor.
// The master side drives windows and samples; the slave side is the monitor itself.
interface toggle_activity_monitor_if
    import act_mon_pkg::*;
#(
    parameter int VEC_W = DEF_VEC_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int WIN_W = DEF_WIN_W
);
    localparam int CNT_W = cnt_width(VEC_W);

    logic             start;
    logic [WIN_W-1:0] window_len;
    logic             in_valid;
    logic [VEC_W-1:0] out_vec;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [ACC_W-1:0] toggle_total;
    logic [CNT_W-1:0] max_toggles;
    logic [WIN_W-1:0] sample_count;

    modport master (
        output start, window_len, in_valid, out_vec, result_ready,
        input  busy, result_valid, toggle_total, max_toggles, sample_count
    );

    modport slave (
        input  start, window_len, in_valid, out_vec, result_ready,
        output busy, result_valid, toggle_total, max_toggles, sample_count
    );

endinterface

// File: rtl/popcount_vec.sv
// Combinational population count of a VEC_W-bit vector.
module popcount_vec
    import act_mon_pkg::*;
#(
    parameter int VEC_W = DEF_VEC_W,
    parameter int CNT_W = cnt_width(VEC_W)
) (
    input  logic [VEC_W-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < VEC_W; i++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Measures bit-toggle activity of a netlist output vector over a window of sampled intervals.
// All outputs come straight from flops; out_vec only reaches state through the popcount.
module toggle_activity_monitor
    import act_mon_pkg::*;
#(
    parameter int VEC_W = DEF_VEC_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    toggle_activity_monitor_if.slave bus
);
    localparam int               CNT_W   = cnt_width(VEC_W);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_e           state_q;
    logic [VEC_W-1:0] prev_q;
    logic [WIN_W-1:0] len_q;
    logic [ACC_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             rvalid_q;

    logic [CNT_W-1:0] pc;
    logic [ACC_W:0]   sum_wide;

    popcount_vec #(
        .VEC_W (VEC_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .vec_i (bus.out_vec ^ prev_q),
        .cnt_o (pc)
    );

    // One extra carry bit detects overflow so the total clamps instead of wrapping.
    always_comb begin
        sum_wide = {1'b0, total_q} + (ACC_W+1)'(pc);
        total_d  = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
        max_d    = (pc > max_q) ? pc : max_q;
        cnt_d    = cnt_q + WIN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            len_q    <= '0;
            total_q  <= '0;
            max_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_q   <= bus.window_len;
                        total_q <= '0;
                        max_q   <= '0;
                        cnt_q   <= '0;
                        if (bus.window_len == '0) begin
                            state_q  <= REPORT;
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q <= PRIME;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                PRIME: begin
                    if (bus.in_valid) begin
                        prev_q  <= bus.out_vec;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        prev_q  <= bus.out_vec;
                        total_q <= total_d;
                        max_q   <= max_d;
                        cnt_q   <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q  <= REPORT;
                            busy_q   <= 1'b0;
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    // A start arriving with the handshake is dropped, not queued.
                    if (bus.result_ready) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = rvalid_q;
    assign bus.toggle_total = total_q;
    assign bus.max_toggles  = max_q;
    assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench: two monitors (default and 8-bit accumulator) share one stimulus stream,
// a window-level model recomputes results from the recorded sample list every cycle.
module tb_toggle_activity_monitor;

    logic        clk = 1'b0;
    logic        rs  = 1'b1;
    logic        st  = 1'b0;
    logic [15:0] wl  = '0;
    logic        iv  = 1'b0;
    logic [65:0] ov  = '0;
    logic        rr  = 1'b0;

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    toggle_activity_monitor_if                bus  ();
    toggle_activity_monitor_if #(.ACC_W(8))   bus8 ();

    assign bus.start         = st;
    assign bus.window_len    = wl;
    assign bus.in_valid      = iv;
    assign bus.out_vec       = ov;
    assign bus.result_ready  = rr;
    assign bus8.start        = st;
    assign bus8.window_len   = wl;
    assign bus8.in_valid     = iv;
    assign bus8.out_vec      = ov;
    assign bus8.result_ready = rr;

    toggle_activity_monitor dut (
        .clk (clk),
        .rst (rs),
        .bus (bus)
    );

    toggle_activity_monitor #(.ACC_W(8)) dut8 (
        .clk (clk),
        .rst (rs),
        .bus (bus8)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Window model: 0 = no window, 1 = collecting samples, 2 = holding a result.
    logic [65:0] q[$];
    int          mode  = 0;
    int          mlen  = 0;
    bit          armed = 0;
    int          tot, mx, cnt, t;

    always @(posedge clk) begin
        if (rs) begin
            mode = 0;
            q.delete();
            armed = 1;
        end else begin
            case (mode)
                0: if (st) begin
                    mlen = int'(wl);
                    q.delete();
                    mode = (wl == 0) ? 2 : 1;
                end
                1: if (iv) begin
                    q.push_back(ov);
                    if (q.size() > 1 && q.size() - 1 == mlen) mode = 2;
                end
                default: if (rr) mode = 0;
            endcase
        end
        #1;
        if (armed) begin
            tot = 0;
            mx  = 0;
            for (int i = 1; i < q.size(); i++) begin
                t = $countones(q[i] ^ q[i-1]);
                tot += t;
                if (t > mx) mx = t;
            end
            cnt = (q.size() > 1) ? q.size() - 1 : 0;
            chk("busy",          int'(bus.busy),          int'(mode == 1));
            chk("result_valid",  int'(bus.result_valid),  int'(mode == 2));
            chk("toggle_total",  int'(bus.toggle_total),  (tot > 24'hFFFFFF) ? 24'hFFFFFF : tot);
            chk("max_toggles",   int'(bus.max_toggles),   mx);
            chk("sample_count",  int'(bus.sample_count),  cnt);
            chk("sat_busy",      int'(bus8.busy),         int'(mode == 1));
            chk("sat_valid",     int'(bus8.result_valid), int'(mode == 2));
            chk("sat_total",     int'(bus8.toggle_total), (tot > 255) ? 255 : tot);
        end
    end

    task automatic drive(input logic s, input logic [15:0] w, input logic v,
                         input logic [65:0] o, input logic r, input logic x);
        @(negedge clk);
        st = s; wl = w; iv = v; ov = o; rr = r; rs = x;
    endtask

    task automatic smp(input logic [65:0] o);
        drive(1'b0, 16'd0, 1'b1, o, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 16'd0, 1'b0, '0, r, 1'b0);
    endtask

    task automatic start_win(input logic [15:0] w);
        drive(1'b1, w, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm, input int b, input int v, input int tt,
                       input int m, input int c);
        chk({nm, " busy"},  int'(bus.busy),         b);
        chk({nm, " valid"}, int'(bus.result_valid), v);
        chk({nm, " total"}, int'(bus.toggle_total), tt);
        chk({nm, " max"},   int'(bus.max_toggles),  m);
        chk({nm, " count"}, int'(bus.sample_count), c);
    endtask

    logic [65:0] ones;
    logic [65:0] zero;

    initial begin
        ones = '1;
        zero = '0;

        drive(1'b0, 16'd0, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b0);
        lit("reset", 0, 0, 0, 0, 0);

        // Quiet window of three intervals.
        start_win(16'd3);
        repeat (4) smp(zero);
        idle(1'b0);
        lit("quiet", 0, 1, 0, 0, 3);
        idle(1'b1);
        idle(1'b0);

        // Every bit flips each interval.
        start_win(16'd2);
        smp(zero); smp(ones); smp(zero);
        idle(1'b0);
        lit("flip", 0, 1, 132, 66, 2);
        chk("flip sat_total", int'(bus8.toggle_total), 132);
        idle(1'b1);
        idle(1'b0);

        // Zero-length window; samples offered while reporting are ignored.
        start_win(16'd0);
        smp(ones);
        idle(1'b0);
        lit("zero_len", 0, 1, 0, 0, 0);
        drive(1'b1, 16'd5, 1'b0, '0, 1'b1, 1'b0);
        idle(1'b0);
        lit("hs_start", 0, 0, 0, 0, 0);

        // Gaps, a stray start mid-window, then a stalled consumer.
        start_win(16'd4);
        smp(66'h0);
        idle(1'b0);
        smp(66'h3);
        drive(1'b1, 16'd7, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0);
        smp(66'hF);
        smp(66'h0);
        idle(1'b0);
        smp(66'h1);
        repeat (5) drive(1'b0, 16'd0, 1'b1, ones, 1'b0, 1'b0);
        idle(1'b0);
        lit("backpressure", 0, 1, 9, 4, 4);
        idle(1'b1);
        idle(1'b0);
        chk("after_hs valid", int'(bus.result_valid), 0);

        // Reset in the middle of a window.
        start_win(16'd5);
        smp(zero); smp(ones); smp(ones);
        drive(1'b0, 16'd0, 1'b1, zero, 1'b1, 1'b1);
        idle(1'b0);
        lit("mid_reset", 0, 0, 0, 0, 0);
        repeat (3) idle(1'b1);

        // Saturation of the narrow accumulator.
        start_win(16'd5);
        smp(zero); smp(ones); smp(zero); smp(ones); smp(zero); smp(ones);
        idle(1'b0);
        lit("sat_wide", 0, 1, 330, 66, 5);
        chk("sat narrow total", int'(bus8.toggle_total), 255);
        chk("sat narrow count", int'(bus8.sample_count), 5);
        idle(1'b1);
        repeat (2) idle(1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

Interface
REQ-001 SHALL have parameter VEC_W, default 66, meaning the width of the monitored output vector of the upstream synthesized benchmark netlist.
REQ-002 SHALL have parameter ACC_W, default 24, meaning the width of the toggle accumulator.
REQ-003 SHALL have parameter WIN_W, default 16, meaning the width of the window-length and sample-count fields.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle pulse that begins a measurement window.
REQ-007 window_len  input  WIN_W  number of toggle intervals to measure; latched on an accepted start.
REQ-008 in_valid  input  1  out_vec carries a new sample this cycle.
REQ-009 out_vec  input  VEC_W  combinational outputs of the benchmark netlist under test.
REQ-010 busy  output  1  a window is in progress.
REQ-011 result_valid  output  1  result fields are valid.
REQ-012 result_ready  input  1  consumer accepts the result.
REQ-013 toggle_total  output  ACC_W  sum of bit toggles over the window.
REQ-014 max_toggles  output  7  largest single-interval toggle count in the window.
REQ-015 sample_count  output  WIN_W  number of intervals counted.

Function
REQ-016 SHALL implement states IDLE, PRIME, ACCUM and REPORT.
REQ-017 IDLE: start=1 SHALL latch window_len, clear the accumulators and go to PRIME; if the latched window_len is 0, it SHALL go to REPORT instead.
REQ-018 PRIME: the first in_valid sample SHALL be stored as the previous vector without counting, then the FSM SHALL go to ACCUM.
REQ-019 ACCUM, per in_valid sample:
- t = popcount(out_vec XOR prev).
- toggle_total += t.
- max_toggles = max(max_toggles, t).
- sample_count += 1.
- prev = out_vec.
REQ-020 In ACCUM, when sample_count reaches the latched window_len, the FSM SHALL go to REPORT.
REQ-021 Accumulator updates SHALL be visible one cycle after the accepting edge.
REQ-022 Cycles with in_valid=0 SHALL leave all state unchanged.
REQ-023 toggle_total SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-024 REPORT: result_valid=1 and result fields held stable until result_valid && result_ready, then go to IDLE.
REQ-025 When result_valid && result_ready and start are high in the same cycle, the FSM SHALL go to IDLE; start SHALL be ignored in that cycle.
REQ-026 busy SHALL be 1 in PRIME and ACCUM, and 0 otherwise.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 in_valid samples SHALL be ignored in IDLE and REPORT.
REQ-029 max_toggles width SHALL hold VEC_W; for the default VEC_W=66 the maximum value 66 fits in 7 bits.

Reset
REQ-030 rst=1 SHALL force IDLE and clear prev, toggle_total, max_toggles, sample_count, busy and result_valid to 0.
REQ-031 rst SHALL take priority over all other inputs in every state.
REQ-032 A rst mid-window SHALL discard the partial result, with no result_valid pulse.

Structure
REQ-033 A shared package act_mon_pkg SHALL hold:
- the state enum;
- the default VEC_W, ACC_W and WIN_W constants.
REQ-034 The population count SHALL be a separate combinational sub-module popcount_vec, parameterized by VEC_W.
REQ-035 Apart from popcount_vec, the block SHALL contain no other sub-module and no combinational path from out_vec to any output.

Verification
REQ-036 Window with no toggles: start, window_len=3; samples 0, 0, 0, 0 -> toggle_total=0, max_toggles=0, sample_count=3, result_valid=1.
REQ-037 Full flips: window_len=2; samples all-0, all-1, all-0 -> toggle_total=132, max_toggles=66.
REQ-038 Zero-length window: window_len=0 start -> REPORT next cycle with all result fields 0; in_valid is ignored.
REQ-039 Gaps and backpressure: window_len=4 with in_valid gaps, result_ready held low for 5 cycles -> results stable and busy=0 until the handshake, then IDLE.
REQ-040 Reset mid-window: rst during ACCUM -> all outputs 0 next cycle, and no result_valid appears.
REQ-041 Saturation: ACC_W=8, window_len=5, all-0/all-1 alternating -> toggle_total=255.
